// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Purpose:
//   Input-side conditioning for the board push buttons (BTN0..3) and DIP
//   switches (SW0..3). Each raw, asynchronous and bouncy input is brought
//   into clk_main through a two-flop synchroniser. It is then debounced by a
//   consecutive-sample counter that advances only on sample_tick, normally an
//   NCO pulse of about 1 kHz. The block produces a clean level per channel
//   plus one-cycle rise/fall pulses for the top level.
//
// Optional feature (compile-time macro BUTTON_DEBOUNCER_LONG_PRESS_EN):
//   When defined, each channel gets a hold counter. long_press pulses once per
//   press after level_out has been high for LONG_PRESS_TICKS sample ticks.
//   When undefined, long_press is tied low and no hold counters exist. The
//   port list is the same in both builds.
//
// Parameters:
//   NUM_INPUTS        number of channels (0..3 = BTN0..3, 4..7 = SW0..3)
//   DEBOUNCE_TICKS    consecutive differing samples needed to accept a new
//                     level (1..255)
//   LONG_PRESS_TICKS  ticks with level high before long_press fires (>= 1)
//
// Ports:
//   clk_main     in   1           system clock
//   reset_n      in   1           asynchronous active-low reset (all flops)
//   sample_tick  in   1           one-cycle sample enable; tie high for
//                                 clock-rate debouncing
//   raw_in       in   NUM_INPUTS  unsynchronised raw levels, active-high
//   level_out    out  NUM_INPUTS  debounced level per channel
//   rise_pulse   out  NUM_INPUTS  one-cycle pulse when level_out goes 0->1
//   fall_pulse   out  NUM_INPUTS  one-cycle pulse when level_out goes 1->0
//   any_change   out  1           OR of rise_pulse and fall_pulse
//   long_press   out  NUM_INPUTS  one-cycle pulse per long hold (optional)
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int NUM_INPUTS       = 8,
    parameter int DEBOUNCE_TICKS   = 16,
    parameter int LONG_PRESS_TICKS = 1000
) (
    input  logic                  clk_main,
    input  logic                  reset_n,
    input  logic                  sample_tick,
    input  logic [NUM_INPUTS-1:0] raw_in,
    output logic [NUM_INPUTS-1:0] level_out,
    output logic [NUM_INPUTS-1:0] rise_pulse,
    output logic [NUM_INPUTS-1:0] fall_pulse,
    output logic                  any_change,
    output logic [NUM_INPUTS-1:0] long_press
);

    // Elaboration-time guard on the legal parameter ranges.
    if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255 || LONG_PRESS_TICKS < 1) begin : g_param_check
        $error("button_debouncer: DEBOUNCE_TICKS must be 1..255 and LONG_PRESS_TICKS >= 1");
    end

    localparam int               CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    // Settling counter advance. It never passes CNT_LAST because reaching
    // CNT_LAST with a differing sample accepts the level and clears it.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt);
        return cnt + CNT_W'(1);
    endfunction

    logic [NUM_INPUTS-1:0]            r_sync_p0;
    logic [NUM_INPUTS-1:0]            r_sync_p1;
    logic [NUM_INPUTS-1:0][CNT_W-1:0] r_cnt_p2;
    logic [NUM_INPUTS-1:0]            r_level_p2;
    logic [NUM_INPUTS-1:0]            r_rise_p2;
    logic [NUM_INPUTS-1:0]            r_fall_p2;
    logic                             r_any_p2;

    logic [NUM_INPUTS-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [NUM_INPUTS-1:0]            w_level_nxt;
    logic [NUM_INPUTS-1:0]            w_rise_nxt;
    logic [NUM_INPUTS-1:0]            w_fall_nxt;

    // ---- Stage p0/p1: two-flop synchroniser; only r_sync_p1 is used below
    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= raw_in;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // ---- Stage p2: per-channel debounce. cnt==0 is STABLE, cnt>0 is SETTLING.
    // A sample matching the current level aborts settling, so only an
    // unbroken run of DEBOUNCE_TICKS differing samples flips the level.
    always_comb begin
        w_cnt_nxt   = r_cnt_p2;
        w_level_nxt = r_level_p2;
        w_rise_nxt  = '0;
        w_fall_nxt  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sample_tick) begin
                if (r_sync_p1[i] == r_level_p2[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt_p2[i] == CNT_LAST) begin
                    w_cnt_nxt[i]   = '0;
                    w_level_nxt[i] = r_sync_p1[i];
                    w_rise_nxt[i]  = r_sync_p1[i];
                    w_fall_nxt[i]  = ~r_sync_p1[i];
                end else begin
                    w_cnt_nxt[i] = cnt_step(r_cnt_p2[i]);
                end
            end
        end
    end

    // Pulses are registered on the same edge as the level, so each pulse
    // coincides with the first cycle the new level is visible.
    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_p2   <= '0;
            r_level_p2 <= '0;
            r_rise_p2  <= '0;
            r_fall_p2  <= '0;
            r_any_p2   <= 1'b0;
        end else begin
            r_cnt_p2   <= w_cnt_nxt;
            r_level_p2 <= w_level_nxt;
            r_rise_p2  <= w_rise_nxt;
            r_fall_p2  <= w_fall_nxt;
            r_any_p2   <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign level_out  = r_level_p2;
    assign rise_pulse = r_rise_p2;
    assign fall_pulse = r_fall_p2;
    assign any_change = r_any_p2;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int                HOLD_W    = $clog2(LONG_PRESS_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_PRESS_TICKS - 1);

    // Saturating hold-counter increment: parks at HOLD_MAX so a press held
    // indefinitely reports exactly once.
    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] hold);
        if (hold >= HOLD_MAX) begin
            return HOLD_MAX;
        end
        return hold + HOLD_W'(1);
    endfunction

    logic [NUM_INPUTS-1:0][HOLD_W-1:0] r_hold_p3;
    logic [NUM_INPUTS-1:0]             r_long_p3;
    logic [NUM_INPUTS-1:0][HOLD_W-1:0] w_hold_nxt;
    logic [NUM_INPUTS-1:0]             w_long_nxt;

    // ---- Stage p3: hold timing on the debounced level
    always_comb begin
        w_hold_nxt = r_hold_p3;
        w_long_nxt = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!r_level_p2[i]) begin
                w_hold_nxt[i] = '0;
            end else if (sample_tick && (r_hold_p3[i] != HOLD_MAX)) begin
                w_hold_nxt[i] = hold_sat_inc(r_hold_p3[i]);
                // Fire on the tick that takes the counter onto HOLD_MAX.
                w_long_nxt[i] = (r_hold_p3[i] == HOLD_PRE);
            end
        end
    end

    always_ff @(posedge clk_main or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_p3 <= '0;
            r_long_p3 <= '0;
        end else begin
            r_hold_p3 <= w_hold_nxt;
            r_long_p3 <= w_long_nxt;
        end
    end

    assign long_press = r_long_p3;
`else
    assign long_press = '0;
`endif

endmodule
